// File: rtl/aes_key_schedule.sv
// AES-128 sequential key expansion.
// aes_round_key_gen derives round key i+1 from round key i (combinational).
// aes_key_schedule steps it once per clock and holds every round key
// in a register file that the cipher datapath reads by round index.

module aes_round_key_gen (
  input  logic [3:0]   rc,
  input  logic [127:0] inkey,
  output logic [127:0] outkey
);

  // Forward S-box; row r of the table holds entries 16r..16r+15, entry 0 in the MSBs.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx  = {b, 3'b000};
    sbox = SBOX[11'd2047 - idx -: 8];
  endfunction

  // Round constant for rounds 1..10; rc 0 maps to round 1.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic [31:0] temp_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;

  // RotWord + SubWord + Rcon on the last word, then the running XOR chain.
  always_comb begin
    w0_s   = inkey[127:96];
    w1_s   = inkey[95:64];
    w2_s   = inkey[63:32];
    w3_s   = inkey[31:0];
    temp_s = {sbox(w3_s[23:16]), sbox(w3_s[15:8]), sbox(w3_s[7:0]), sbox(w3_s[31:24])}
             ^ {rcon(rc), 24'h000000};
    n0_s   = w0_s ^ temp_s;
    n1_s   = n0_s ^ w1_s;
    n2_s   = n1_s ^ w2_s;
    n3_s   = n2_s ^ w3_s;
    outkey = {n0_s, n1_s, n2_s, n3_s};
  end

endmodule

module aes_key_schedule #(
  parameter int NR     = 10,
  parameter int RD_REG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  // Final counter value; rc never goes past it, so it cannot wrap.
  localparam logic [3:0] RC_LAST = 4'(NR - 1);

  state_t       state_q, state_d;
  logic [3:0]   rc_q, rc_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         keys_valid_q, keys_valid_d;
  logic [127:0] key_q [0:NR];
  logic [127:0] key_d [0:NR];

  logic [127:0] gen_inkey_s;
  logic [127:0] gen_outkey_s;
  logic [127:0] rd_sel_s;

  // Single generator instance; its input is always the key indexed by rc.
  aes_round_key_gen u_gen (
    .rc     (rc_q),
    .inkey  (gen_inkey_s),
    .outkey (gen_outkey_s)
  );

  // Select key[rc] as the generator input (one-hot OR mux).
  always_comb begin
    gen_inkey_s = 128'h0;
    for (int i = 0; i <= NR; i++) begin
      gen_inkey_s = gen_inkey_s | ((rc_q == 4'(i)) ? key_q[i] : 128'h0);
    end
  end

  // Next-state logic for the two-state expansion FSM and the key file.
  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;
    key_d        = key_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d[0]     = key_in;
          rc_d         = 4'd0;
          keys_valid_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_EXPAND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        for (int i = 1; i <= NR; i++) begin
          key_d[i] = (rc_q == 4'(i - 1)) ? gen_outkey_s : key_q[i];
        end
        if (rc_q == RC_LAST) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          keys_valid_d = 1'b1;
          rc_d         = 4'd0;
        end else begin
          rc_d = rc_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rc_d    = 4'd0;
      end
    endcase
  end

  // State, flags and key file; reset clears the whole schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rc_q         <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        key_q[i] <= 128'h0;
      end
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      for (int i = 0; i <= NR; i++) begin
        key_q[i] <= key_d[i];
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;

  // Read mux; indices beyond NR return zero.
  always_comb begin
    rd_sel_s = 128'h0;
    for (int i = 0; i <= NR; i++) begin
      rd_sel_s = rd_sel_s | ((rd_addr == 4'(i)) ? key_q[i] : 128'h0);
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [127:0] rd_key_q;

      // Registered read: rd_key follows rd_addr one edge later.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_key_q <= 128'h0;
        end else begin
          rd_key_q <= rd_sel_s;
        end
      end

      assign rd_key = rd_key_q;
    end else begin : g_rd_comb
      assign rd_key = rd_sel_s;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: one combinational-read and one
// registered-read instance share all inputs.

module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rd_addr;
  logic         busy0, done0, kv0, busy1, done1, kv1;
  logic [127:0] rd_key0, rd_key1;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  always #5 clk = ~clk;

  aes_key_schedule #(.NR(10), .RD_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy0), .done(done0), .keys_valid(kv0),
    .rd_addr(rd_addr), .rd_key(rd_key0)
  );

  aes_key_schedule #(.NR(10), .RD_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy1), .done(done1), .keys_valid(kv1),
    .rd_addr(rd_addr), .rd_key(rd_key1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] fips_at(input int a);
    if (a <= 10) fips_at = FIPS[a];
    else         fips_at = 128'h0;
  endfunction

  // Wait (bounded) for done; lat counts edges after the start edge.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("done_timeout", {127'h0, done0}, 128'h1);
    check("done_sync", {127'h0, done1}, {127'h0, done0});
  endtask

  task automatic start_run(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt;
    logic [127:0] prev;

    rst_n = 1'b0; start = 1'b0; key_in = 128'h0; rd_addr = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {127'h0, busy0}, 128'h0);
    check("rst_done", {127'h0, done0}, 128'h0);
    check("rst_kv", {127'h0, kv0}, 128'h0);
    check("rst_rdkey0", rd_key0, 128'h0);
    check("rst_rdkey1", rd_key1, 128'h0);
    rst_n = 1'b1;

    // FIPS-197 A.1
    start_run(FIPS[0]);
    check("s1_busy", {127'h0, busy0}, 128'h1);
    check("s1_kv_low", {127'h0, kv0}, 128'h0);
    wait_done(lat);
    check("s1_latency", 128'(lat), 128'd10);
    check("s1_busy_at_done", {127'h0, busy0}, 128'h0);
    check("s1_kv", {127'h0, kv0}, 128'h1);
    @(negedge clk);
    check("s1_done_pulse", {127'h0, done0}, 128'h0);
    check("s1_kv_hold", {127'h0, kv0}, 128'h1);

    // Read sweep, both read styles
    rd_addr = 4'd15;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      prev = (a == 0) ? 128'h0 : fips_at(a - 1);
      rd_addr = 4'(a);
      #1;
      check($sformatf("s6_comb_%0d", a), rd_key0, fips_at(a));
      check($sformatf("s6_reg_prev_%0d", a), rd_key1, prev);
      @(negedge clk);
      check($sformatf("s6_reg_%0d", a), rd_key1, fips_at(a));
    end

    // All-zero key
    start_run(128'h0);
    wait_done(lat);
    check("s2_latency", 128'(lat), 128'd10);
    rd_addr = 4'd1; #1;
    check("s2_key1", rd_key0, 128'h62636363626363636263636362636363);
    rd_addr = 4'd10; #1;
    check("s2_key10", rd_key0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // start pulses during expansion are ignored
    @(negedge clk);
    key_in = FIPS[0]; start = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 3 || n == 7) begin
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      if (done0) cnt++;
    end
    check("s3_done_count", 128'(cnt), 128'd1);
    for (int a = 0; a <= 10; a++) begin
      rd_addr = 4'(a); #1;
      check($sformatf("s3_key_%0d", a), rd_key0, FIPS[a]);
    end

    // Reset in the middle of expansion
    start_run(FIPS[0]);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("s4_busy", {127'h0, busy0}, 128'h0);
    check("s4_done", {127'h0, done0}, 128'h0);
    check("s4_kv", {127'h0, kv0}, 128'h0);
    check("s4_rd_reg", rd_key1, 128'h0);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      check($sformatf("s4_zero_%0d", a), rd_key0, 128'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_run(128'h0);
    wait_done(lat);
    check("s4_latency", 128'(lat), 128'd10);
    rd_addr = 4'd10; #1;
    check("s4_key10", rd_key0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // start held high: done every 11 cycles, keys_valid only in done cycle
    @(negedge clk);
    key_in = FIPS[0]; start = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      check($sformatf("s5_done_%0d", n), {127'h0, done0}, {127'h0, (n % 11 == 0)});
      check($sformatf("s5_kv_%0d", n), {127'h0, kv0}, {127'h0, done0});
    end
    start = 1'b0;
    @(negedge clk);
    check("s5_kv_final", {127'h0, kv0}, 128'h1);
    check("s5_busy_final", {127'h0, busy0}, 128'h0);
    rd_addr = 4'd10; #1;
    check("s5_key10", rd_key0, FIPS[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
